// File: rtl/eth_tx_arb_pkg.sv
// Shared types and defaults for the transmit arbiter.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam int IFG_CYC_DEF = 2;
    localparam int WDT_CYC_DEF = 64;

endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational and independent of the arbiter, so the TCP/UDP
// demux can reuse it.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter in front of the UDP/IPv4/MAC tx stack.
// Optional stall watchdog: define ETH_TX_ARB_WATCHDOG_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; pick a requester from ptr on the next edge
// GRANT | one source owns the stack; its beats go through the mux
// GAP   | inter-frame gap, counts IFG_CYC-1 down to 0, then IDLE
module eth_tx_arb
    import eth_tx_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = $clog2(DATA_W/8+1),
    parameter int IFG_CYC = IFG_CYC_DEF,
    parameter int WDT_CYC = WDT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [NREQ-1:0]        req_i,
    output logic [NREQ-1:0]        grant_o,
    input  logic [NREQ-1:0]        src_valid_i,
    input  logic [NREQ-1:0]        src_start_i,
    input  logic [NREQ-1:0]        src_term_i,
    input  logic [NREQ-1:0]        src_cancel_i,
    input  logic [NREQ*DATA_W-1:0] src_data_i,
    input  logic [NREQ*LEN_W-1:0]  src_len_i,
    output logic                   valid_o,
    output logic                   start_o,
    output logic                   term_o,
    output logic                   cancel_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [LEN_W-1:0]       len_o,
    output logic                   busy_o
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int GAP_W = (IFG_CYC < 2) ? 1 : $clog2(IFG_CYC);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              in_frame_q, in_frame_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic              term_q, term_d;
    logic              cancel_q, cancel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]  pick_idx;

    logic              sel_req, sel_valid, sel_start, sel_term, sel_cancel;
    logic [DATA_W-1:0] sel_data;
    logic [LEN_W-1:0]  sel_len;

    logic              fwd, abort, withdraw, end_frame;
    logic              wdt_hit;

    rr_pick #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Only the owner's inputs are ever looked at.
    assign sel_req    = req_i[gidx_q];
    assign sel_valid  = src_valid_i[gidx_q];
    assign sel_start  = src_start_i[gidx_q];
    assign sel_term   = src_term_i[gidx_q];
    assign sel_cancel = src_cancel_i[gidx_q];
    assign sel_data   = src_data_i[int'(gidx_q)*DATA_W +: DATA_W];
    assign sel_len    = src_len_i[int'(gidx_q)*LEN_W +: LEN_W];

`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYC + 1);

    logic [WDT_W-1:0] wdt_cnt_q;
    logic             stall;

    assign stall   = (state_q == GRANT) && !sel_valid;
    assign wdt_hit = stall && (wdt_cnt_q == WDT_W'(1));

    // Remaining stall budget; re-armed by any owner beat or outside GRANT.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            wdt_cnt_q <= WDT_W'(WDT_CYC);
        else if (!stall || wdt_hit)
            wdt_cnt_q <= WDT_W'(WDT_CYC);
        else
            wdt_cnt_q <= wdt_cnt_q - WDT_W'(1);
    end
`else
    // No watchdog: a stalled owner keeps the stack. WDT_CYC has no role here,
    // the compare folds to 0.
    assign wdt_hit = (WDT_CYC < 0);
`endif

    // Next-state, grant bookkeeping and the registered mux inputs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        in_frame_d = in_frame_q;
        gap_d      = gap_q;
        valid_d    = 1'b0;
        start_d    = 1'b0;
        term_d     = 1'b0;
        cancel_d   = 1'b0;
        data_d     = data_q;
        len_d      = len_q;
        fwd        = 1'b0;
        abort      = 1'b0;
        withdraw   = 1'b0;
        end_frame  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d    = pick_gnt;
                    gidx_d     = pick_idx;
                    ptr_d      = (pick_idx == IDX_W'(NREQ-1)) ? '0 : pick_idx + IDX_W'(1);
                    in_frame_d = 1'b0;
                    state_d    = GRANT;
                end
            end

            GRANT: begin
                // Beats before a start are dropped; cancel beats the term.
                fwd      = sel_valid && (in_frame_q || sel_start);
                abort    = sel_cancel || wdt_hit;
                withdraw = !in_frame_q && !sel_req;
                if (abort) begin
                    cancel_d  = 1'b1;
                    end_frame = 1'b1;
                end else if (withdraw) begin
                    grant_d    = '0;
                    in_frame_d = 1'b0;
                    state_d    = IDLE;
                end else if (fwd) begin
                    valid_d = 1'b1;
                    start_d = sel_start;
                    term_d  = sel_term;
                    data_d  = sel_data;
                    len_d   = sel_len;
                    if (sel_start)
                        in_frame_d = 1'b1;
                    if (sel_term)
                        end_frame = 1'b1;
                end

                if (end_frame) begin
                    grant_d    = '0;
                    in_frame_d = 1'b0;
                    if (IFG_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(IFG_CYC - 1);
                    end
                end
            end

            GAP: begin
                if (gap_q == '0)
                    state_d = IDLE;
                else
                    gap_d = gap_q - GAP_W'(1);
            end

            default: state_d = IDLE;
        endcase
    end

    // State, grant and output stream registers; all clear on reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            in_frame_q <= 1'b0;
            gap_q      <= '0;
            valid_q    <= 1'b0;
            start_q    <= 1'b0;
            term_q     <= 1'b0;
            cancel_q   <= 1'b0;
            data_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            in_frame_q <= in_frame_d;
            gap_q      <= gap_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            term_q     <= term_d;
            cancel_q   <= cancel_d;
            data_q     <= data_d;
            len_q      <= len_d;
        end
    end

    assign grant_o  = grant_q;
    assign valid_o  = valid_q;
    assign start_o  = start_q;
    assign term_o   = term_q;
    assign cancel_o = cancel_q;
    assign data_o   = data_q;
    assign len_o    = len_q;
    assign busy_o   = (state_q != IDLE);

endmodule
